// File: rtl/gpu_irq_ctrl.sv
// GPU interrupt controller: five edge-triggered sources, enable/latch flag register,
// highest-index priority and a request/acknowledge/in-service handshake to the pipeline.
module gpu_irq_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [0:4]  gpu_irq,
  input  logic        flagwr,
  input  logic [0:31] gpu_din,
  input  logic        flagrd,
  input  logic        int_ack,
  output logic        int_req,
  output logic [0:2]  int_vec,
  output logic        imask,
  inout  wire  [0:15] gpu_dout
);

  typedef enum logic [1:0] {IDLE, REQ, SERV} state_t;

  state_t      state_reg;
  logic [0:4]  irq_reg;
  logic        primed_reg;
  logic [0:4]  lat_reg;
  logic [0:4]  lat_next;
  logic [0:4]  ena_reg;
  logic        imask_reg;
  logic        int_req_reg;
  logic [0:2]  int_vec_reg;

  logic [0:4]  edge_pulse;
  logic [0:4]  pend;
  logic        pending;
  logic        accept;
  logic [0:2]  win_idx;
  logic [0:15] status;

  // Only flag bits 3-13 carry meaning; the rest of the bus is deliberately ignored.
  logic unused_din;
  assign unused_din = ^{gpu_din[0:2], gpu_din[14:31]};

  // No edge may be reported until irq_reg has sampled the lines at least once after reset.
  assign edge_pulse = gpu_irq & ~irq_reg & {5{primed_reg}};
  assign pend       = lat_reg & ena_reg;
  assign pending    = |pend;
  assign accept     = (state_reg == REQ) && int_ack;

  always_comb begin
    win_idx = 3'd0;
    for (int i = 0; i < 5; i++) begin
      if (pend[i]) win_idx = 3'(i);
    end
  end

  // A fresh edge beats a software clear or an acknowledge clear in the same cycle.
  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_lat
      assign lat_next[gi] = (edge_pulse[gi] & ena_reg[gi]) |
                            (lat_reg[gi] & ~(flagwr & gpu_din[9+gi])
                                         & ~(accept && (int_vec_reg == 3'(gi))));
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      irq_reg     <= '0;
      primed_reg  <= 1'b0;
      lat_reg     <= '0;
      ena_reg     <= '0;
      imask_reg   <= 1'b0;
      int_req_reg <= 1'b0;
      int_vec_reg <= '0;
    end else begin
      irq_reg    <= gpu_irq;
      primed_reg <= 1'b1;
      lat_reg    <= lat_next;
      if (flagwr) ena_reg <= gpu_din[4:8];

      if (accept) imask_reg <= 1'b1;
      else if (flagwr && !gpu_din[3]) imask_reg <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (pending && !imask_reg) begin
            state_reg   <= REQ;
            int_req_reg <= 1'b1;
            int_vec_reg <= win_idx;
          end
        end
        REQ: begin
          if (int_ack) begin
            state_reg   <= SERV;
            int_req_reg <= 1'b0;
          end
        end
        SERV: begin
          if (!imask_reg) state_reg <= IDLE;
        end
        default: begin
          state_reg   <= IDLE;
          int_req_reg <= 1'b0;
        end
      endcase
    end
  end

  assign int_req = int_req_reg;
  assign int_vec = int_vec_reg;
  assign imask   = imask_reg;

  always_comb begin
    status       = '0;
    status[3]    = imask_reg;
    status[4:8]  = ena_reg;
    status[9:13] = lat_reg;
  end

  assign gpu_dout = flagrd ? status : 16'bz;

endmodule

// File: tb/tb_gpu_irq_ctrl.sv
// Directed bench for gpu_irq_ctrl: expected vectors are queued when sources are
// raised and popped when the controller raises int_req.
module tb_gpu_irq_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [0:4]  gpu_irq;
  logic        flagwr;
  logic [0:31] gpu_din;
  logic        flagrd;
  logic        int_ack;
  logic        int_req;
  logic [0:2]  int_vec;
  logic        imask;
  wire  [0:15] gpu_dout;

  int checks   = 0;
  int failures = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  gpu_irq_ctrl dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .gpu_irq  (gpu_irq),
    .flagwr   (flagwr),
    .gpu_din  (gpu_din),
    .flagrd   (flagrd),
    .int_ack  (int_ack),
    .int_req  (int_req),
    .int_vec  (int_vec),
    .imask    (imask),
    .gpu_dout (gpu_dout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [0:15] status_word(input logic im, input logic [0:4] en,
                                              input logic [0:4] la);
    logic [0:15] s;
    s       = '0;
    s[3]    = im;
    s[4:8]  = en;
    s[9:13] = la;
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic write_flags(input logic im_bit, input logic [0:4] en, input logic [0:4] clr);
    gpu_din       = '0;
    gpu_din[3]    = im_bit;
    gpu_din[4:8]  = en;
    gpu_din[9:13] = clr;
    flagwr        = 1'b1;
    tick();
    flagwr        = 1'b0;
    gpu_din       = '0;
  endtask

  task automatic pulse_irq(input logic [0:4] m);
    gpu_irq = gpu_irq | m;
    tick();
    gpu_irq = gpu_irq & ~m;
  endtask

  task automatic wait_req(input string tag, input int budget);
    int n = 0;
    while (int_req !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(int_req), 32'd1);
  endtask

  task automatic pop_vec(input string tag);
    int e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s observed=scoreboard_empty expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      check(tag, 32'(int_vec), 32'(e));
    end
  endtask

  task automatic serve();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    write_flags(1'b0, 5'b11111, 5'b00000);
  endtask

  initial begin
    reset_n = 1'b0;
    gpu_irq = '0;
    flagwr  = 1'b0;
    gpu_din = '0;
    flagrd  = 1'b1;
    int_ack = 1'b0;
    tick();
    tick();
    check("rst_int_req", 32'(int_req), 32'd0);
    check("rst_int_vec", 32'(int_vec), 32'd0);
    check("rst_imask", 32'(imask), 32'd0);
    check("rst_status", 32'(gpu_dout), 32'(status_word(1'b0, 5'b00000, 5'b00000)));
    reset_n = 1'b1;
    tick();

    // Single source with exact two-cycle latency, then acknowledge.
    write_flags(1'b0, 5'b11111, 5'b00000);
    check("ena_readback", 32'(gpu_dout), 32'(status_word(1'b0, 5'b11111, 5'b00000)));
    gpu_irq[2] = 1'b1;
    exp_q.push_back(2);
    tick();
    gpu_irq[2] = 1'b0;
    check("lat2_set", 32'(gpu_dout), 32'(status_word(1'b0, 5'b11111, 5'b00100)));
    check("req_not_yet", 32'(int_req), 32'd0);
    tick();
    check("req_latency", 32'(int_req), 32'd1);
    pop_vec("vec_src2");
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    check("ack_req_low", 32'(int_req), 32'd0);
    check("ack_status", 32'(gpu_dout), 32'(status_word(1'b1, 5'b11111, 5'b00000)));
    write_flags(1'b1, 5'b11111, 5'b00000);
    check("imask_write1_noop", 32'(imask), 32'd1);
    write_flags(1'b0, 5'b11111, 5'b00000);
    check("imask_clear", 32'(imask), 32'd0);
    tick();

    // Two simultaneous sources: higher index first, lower after the mask clear.
    exp_q.push_back(3);
    exp_q.push_back(1);
    pulse_irq(5'b01010);
    wait_req("req_pair_hi", 4);
    pop_vec("vec_pair_hi");
    serve();
    wait_req("req_pair_lo", 6);
    pop_vec("vec_pair_lo");
    serve();
    tick();

    // Acknowledge outside REQ is ignored.
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    check("ack_idle_ignored", 32'(imask), 32'd0);

    // Disabled source never latches.
    write_flags(1'b0, 5'b00000, 5'b00000);
    pulse_irq(5'b00001);
    tick();
    tick();
    check("disabled_lat4", 32'(gpu_dout[13]), 32'd0);
    check("disabled_no_req", 32'(int_req), 32'd0);
    write_flags(1'b0, 5'b11111, 5'b00000);

    // Source arriving while in service latches but waits for the mask clear.
    exp_q.push_back(3);
    pulse_irq(5'b00010);
    wait_req("req_src3", 4);
    pop_vec("vec_src3");
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    pulse_irq(5'b10000);
    tick();
    tick();
    check("serv_lat0", 32'(gpu_dout[9]), 32'd1);
    check("serv_no_req", 32'(int_req), 32'd0);
    exp_q.push_back(0);
    write_flags(1'b0, 5'b11111, 5'b00000);
    wait_req("req_src0", 6);
    pop_vec("vec_src0");
    serve();
    tick();

    // Edge and clear of the same latch in one cycle: the edge wins.
    gpu_irq[1] = 1'b1;
    write_flags(1'b0, 5'b11111, 5'b01000);
    gpu_irq[1] = 1'b0;
    check("set_beats_clear", 32'(gpu_dout[10]), 32'd1);
    exp_q.push_back(1);
    wait_req("req_src1", 4);
    pop_vec("vec_src1");

    // Higher priority arriving during REQ does not disturb int_vec.
    pulse_irq(5'b00001);
    exp_q.push_back(4);
    tick();
    tick();
    check("vec_held_in_req", 32'(int_vec), 32'd1);
    serve();
    wait_req("req_src4", 6);
    pop_vec("vec_src4");
    serve();
    tick();

    // A line held high produces a single latch set.
    exp_q.push_back(2);
    gpu_irq[2] = 1'b1;
    wait_req("req_held", 5);
    pop_vec("vec_held");
    serve();
    for (int i = 0; i < 4; i++) tick();
    check("held_no_repeat", 32'(int_req), 32'd0);
    check("held_lat_clear", 32'(gpu_dout[11]), 32'd0);
    gpu_irq[2] = 1'b0;
    tick();

    // Asynchronous reset while requesting.
    exp_q.push_back(3);
    pulse_irq(5'b00010);
    wait_req("req_before_rst", 4);
    pop_vec("vec_before_rst");
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_req", 32'(int_req), 32'd0);
    check("async_rst_status", 32'(gpu_dout), 32'(status_word(1'b0, 5'b00000, 5'b00000)));
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check("post_rst_idle", 32'(int_req), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/gpu_irq_ctrl.md
GPU_IRQ_CTRL -- requirements
Module: gpu_irq_ctrl

Interface
REQ-001 Parameters: none; the block is fixed at 5 interrupt sources, numbered 0-4.
REQ-002 clk  in  1  single system clock; every flop is clocked on its rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 gpu_irq  in  5 [0:4]  interrupt lines; bit 0 is the GPU CPU-interrupt pulse from the control block, bits 1-4 are external sources.
REQ-005 flagwr  in  1  one-cycle flag-register write strobe.
REQ-006 gpu_din  in  32 [0:31]  write data; only bits 3-13 are used.
REQ-007 flagrd  in  1  flag-register read enable.
REQ-008 int_ack  in  1  one-cycle pulse from the pipeline meaning the interrupt vector has been taken.
REQ-009 int_req  out  1  interrupt request to the pipeline.
REQ-010 int_vec  out  3 [0:2]  number of the source being requested, 0-4.
REQ-011 imask  out  1  interrupt-in-service flag.
REQ-012 gpu_dout  inout  16 [0:15]  status readback; driven when flagrd=1, high-impedance otherwise.

Function
REQ-013 Edge detect: each gpu_irq bit is registered once; a rising edge (previous 0, current 1) creates a one-cycle pulse for that source.
REQ-014 Latches: each edge pulse sets lat[i]; the pulse is ignored while ena[i]=0.
REQ-015 Latch clear: flagwr with gpu_din[9+i]=1 clears lat[i]; if a set and a clear for the same bit fall in the same cycle, the set wins.
REQ-016 Enables: flagwr loads ena[0:4] from gpu_din[4:8]; clearing ena[i] does not clear an existing lat[i].
REQ-017 Pending: pend[i] = lat[i] AND ena[i]; pending = OR of pend.
REQ-018 Priority: the highest pending index wins (4 highest, 0 lowest); int_vec = index of that winner.
REQ-019 States: IDLE, REQ, SERV.
- IDLE -> REQ when pending=1 and imask=0.
- REQ -> SERV on int_ack.
- SERV -> IDLE when imask is cleared.
REQ-020 int_req = 1 exactly while in REQ.
REQ-021 int_vec is captured on the IDLE->REQ transition and held constant through REQ and SERV.
REQ-022 On int_ack in REQ: imask is set and lat[int_vec] is cleared in the same edge.
REQ-023 int_ack outside REQ is ignored.
REQ-024 imask is set only by acceptance; flagwr with gpu_din[3]=0 clears it, and writing 1 has no effect.
REQ-025 If imask is cleared while still in REQ, the state stays REQ.
REQ-026 Latency: gpu_irq rising at edge n -> lat set at edge n+1 -> int_req high after edge n+2 when IDLE and imask=0.
REQ-027 A higher-priority source arriving during REQ does not change int_vec; it is serviced on the next IDLE->REQ transition.
REQ-028 Readback layout:
- gpu_dout[3] = imask.
- gpu_dout[4:8] = ena.
- gpu_dout[9:13] = lat.
- gpu_dout[0:2] = 0 and gpu_dout[14:15] = 0.
- Readback is combinational from the registers.
REQ-029 A source held high produces exactly one latch set; a new latch set requires the line to return to 0 and rise again.

Reset
REQ-030 reset_n=0 asynchronously forces the state to IDLE and clears lat, ena, imask, int_vec and the edge registers; int_req goes to 0 immediately.
REQ-031 A reset asserted in REQ or SERV abandons the request; no int_ack is required after reset.
REQ-032 After reset is released, a gpu_irq line that is already high does not create an edge, because the edge registers reset to 0 but are loaded before the first comparison.

Verification
REQ-033 Write flagwr gpu_din[4:8]=11111, then pulse gpu_irq[2] -> int_req=1 two cycles later with int_vec=2; int_ack -> int_req=0, imask=1, lat[2]=0.
REQ-034 With all sources enabled, raise gpu_irq[1] and gpu_irq[3] in the same cycle -> int_vec=3; after service and the imask clear write -> new request with int_vec=1.
REQ-035 With ena=0, pulse gpu_irq[4] -> lat[4] stays 0 and no int_req.
REQ-036 In SERV, pulse gpu_irq[0] -> lat[0]=1 and no int_req; write gpu_din[3]=0 -> IDLE, then int_req=1 with int_vec=0.
REQ-037 In the same cycle, an edge pulse on source 1 and flagwr gpu_din[10]=1 -> lat[1]=1.
REQ-038 Assert reset_n=0 mid-REQ -> int_req=0 asynchronously; the flagrd readback then returns 0x0000.
